// File: rtl/ram_dumper.sv
// Streams RAM addresses 0..RAM_BYTES-1 to a host, one acknowledged byte at a time.
// Optional feature: define RAM_DUMPER_CHECKSUM_EN to append a modulo-256 checksum byte.
module ram_dumper #(
  parameter int RAM_BYTES = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        dumping,
  input  logic        next_byte,
  input  logic [7:0]  bus_in,
  output logic [7:0]  bus_out,
  output logic        bus_drive,
  output logic [14:0] out,
  output logic [7:0]  data_out,
  output logic        data_valid,
  output logic        done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_READ,
    S_PRESENT,
    S_DONE
  } state_t;

  // Control word {Cp,Ep,Lp,nLma,nLmd,nCE,nLr,nLi,nEi,nLa,Ea,sub,Eu,nLb,nLo}
  localparam logic [14:0] OUT_INACTIVE = 15'h0FE3;
  localparam logic [14:0] OUT_LOAD_MAR = 15'h07E3;
  localparam logic [14:0] OUT_RAM_OUT  = 15'h0DE3;
  localparam logic [3:0]  LAST_ADDR    = 4'(RAM_BYTES - 1);

  state_t      state_q, state_d;
  logic [3:0]  addr_q, addr_d;
  logic [7:0]  data_q, data_d;
  logic        valid_q, valid_d;
  logic        nb_q;
  logic        ack;
  logic        ack_taken;

`ifdef RAM_DUMPER_CHECKSUM_EN
  logic [7:0]  sum_q, sum_d;
  logic        csum_q, csum_d;
`endif

  assign ack       = next_byte & ~nb_q;
  assign ack_taken = (state_q == S_PRESENT) && ack;

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    data_d  = data_q;
`ifdef RAM_DUMPER_CHECKSUM_EN
    sum_d   = sum_q;
    csum_d  = csum_q;
`endif
    case (state_q)
      S_IDLE: begin
        addr_d = 4'd0;
`ifdef RAM_DUMPER_CHECKSUM_EN
        sum_d  = 8'h00;
        csum_d = 1'b0;
`endif
        if (dumping) state_d = S_ADDR;
      end
      S_ADDR: state_d = S_READ;
      S_READ: begin
        data_d  = bus_in;
`ifdef RAM_DUMPER_CHECKSUM_EN
        sum_d   = sum_q + bus_in;
`endif
        state_d = S_PRESENT;
      end
      S_PRESENT: begin
        if (ack) begin
`ifdef RAM_DUMPER_CHECKSUM_EN
          if (csum_q) begin
            state_d = S_DONE;
          end else if (addr_q < LAST_ADDR) begin
            addr_d  = addr_q + 4'd1;
            state_d = S_ADDR;
          end else begin
            // Checksum goes out as an extra transfer without touching the bus.
            csum_d  = 1'b1;
            data_d  = sum_q;
            state_d = S_PRESENT;
          end
`else
          if (addr_q < LAST_ADDR) begin
            addr_d  = addr_q + 4'd1;
            state_d = S_ADDR;
          end else begin
            state_d = S_DONE;
          end
`endif
        end
      end
      S_DONE: state_d = S_DONE;
      default: state_d = S_IDLE;
    endcase

    if (!dumping) begin
      state_d = S_IDLE;
      addr_d  = 4'd0;
`ifdef RAM_DUMPER_CHECKSUM_EN
      csum_d  = 1'b0;
`endif
    end

    // An acknowledged byte always loses valid for at least one cycle.
    valid_d = (state_d == S_PRESENT) && !ack_taken;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      addr_q  <= 4'd0;
      data_q  <= 8'h00;
      valid_q <= 1'b0;
      nb_q    <= 1'b0;
`ifdef RAM_DUMPER_CHECKSUM_EN
      sum_q   <= 8'h00;
      csum_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      nb_q    <= next_byte;
`ifdef RAM_DUMPER_CHECKSUM_EN
      sum_q   <= sum_d;
      csum_q  <= csum_d;
`endif
    end
  end

  always_comb begin
    out = OUT_INACTIVE;
    case (state_q)
      S_ADDR:  out = OUT_LOAD_MAR;
      S_READ:  out = OUT_RAM_OUT;
      default: out = OUT_INACTIVE;
    endcase
  end

  assign bus_drive  = (state_q == S_ADDR);
  assign bus_out    = bus_drive ? {4'b0000, addr_q} : 8'h00;
  assign data_out   = data_q;
  assign data_valid = valid_q;
  assign done       = (state_q == S_DONE);

endmodule

// File: doc/ram_dumper.md
RAM_DUMPER -- requirements
Module: ram_dumper

Interface
REQ-001 SHALL have parameter RAM_BYTES, default 16, number of RAM addresses dumped (address width 4 bits).
REQ-002 SHALL have ports `clk`  input  1  rising-edge clock; one clock domain only.
REQ-003 SHALL have port `rst`  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port `dumping`  input  1  dump-mode request; it is a level signal.
REQ-005 SHALL have port `next_byte`  input  1  host acknowledge; only its rising edge is acted on.
REQ-006 SHALL have port `bus_in`  input  8  current value of the CPU bus.
REQ-007 SHALL have port `bus_out`  output  8  value this block drives onto the bus.
REQ-008 SHALL have port `bus_drive`  output  1  tri-state enable for `bus_out`.
REQ-009 SHALL have port `out`  output  15  control word; the bit layout is {Cp,Ep,Lp,nLma,nLmd,nCE,nLr,nLi,nEi,nLa,Ea,sub,Eu,nLb,nLo}, with bit 14 = Cp.
REQ-010 SHALL have port `data_out`  output  8  byte presented to the host.
REQ-011 SHALL have port `data_valid`  output  1  `data_out` holds a valid, unacknowledged byte.
REQ-012 SHALL have port `done`  output  1  dump complete.

Function
REQ-013 SHALL implement the states IDLE, ADDR, READ, PRESENT and DONE.
REQ-014 SHALL drive `out` = 15'h0FE3 (all units inactive) in IDLE, PRESENT and DONE.
REQ-015 SHALL, in IDLE, move to ADDR on the first cycle `dumping`=1, with the address counter at 0.
REQ-016 SHALL, in ADDR (one cycle), drive `bus_drive`=1, `bus_out`={4'b0,addr} and `out`=15'h07E3 (nLma low), so the MAR latches the address.
REQ-017 SHALL, in READ (one cycle), drive `bus_drive`=0 and `out`=15'h0DE3 (nCE low); it SHALL capture `bus_in` into `data_out` at the closing clock edge.
REQ-018 SHALL, in PRESENT, hold `data_valid`=1 and keep `data_out` stable until a `next_byte` rising edge is detected.
REQ-019 SHALL detect a rising edge on a registered copy of `next_byte` (previous 0, current 1); a level held high SHALL count as one edge only.
REQ-020 SHALL ignore `next_byte` edges outside PRESENT; they SHALL NOT be remembered.
REQ-021 SHALL, on an acknowledge in PRESENT, clear `data_valid` in the next cycle.
REQ-022 SHALL, after the acknowledge in PRESENT, increment the address and go to ADDR if the address was below RAM_BYTES-1; otherwise it SHALL go to DONE.
REQ-023 SHALL take 2 cycles + host wait per byte; a minimal dump takes 3 x RAM_BYTES cycles.
REQ-024 SHALL, in DONE, hold `done`=1 and `data_valid`=0 until `dumping`=0, then return to IDLE.
REQ-025 SHALL abort to IDLE on the next edge if `dumping` falls in any state; the address SHALL be cleared and `data_valid` cleared.
REQ-026 SHALL never assert `bus_drive` outside ADDR.
REQ-027 SHALL wrap the address counter modulo 16; no out-of-range access SHALL occur.

Reset
REQ-028 SHALL, while `rst`=1 at a clock edge, go to IDLE with addr=0, `data_out`=8'h00, `data_valid`=0, `done`=0, `bus_drive`=0, `bus_out`=8'h00, `out`=15'h0FE3, and the edge-detect register =0.
REQ-029 SHALL give `rst` priority over every other input, including in mid-dump; after reset a new dump restarts at address 0.

Configuration
REQ-030 SHALL recognise the macro `RAM_DUMPER_CHECKSUM_EN`.
REQ-031 SHALL, when `RAM_DUMPER_CHECKSUM_EN` is defined, accumulate an 8-bit modulo-256 sum of every captured byte; the sum SHALL be cleared in IDLE and on reset.
REQ-032 SHALL, when `RAM_DUMPER_CHECKSUM_EN` is defined, follow the last RAM byte's acknowledge with one extra PRESENT transfer carrying the sum (no ADDR/READ; `out` stays 15'h0FE3), and enter DONE only after its acknowledge.
REQ-033 SHALL, when `RAM_DUMPER_CHECKSUM_EN` is undefined, contain no checksum logic and enter DONE directly after the last RAM byte.

Verification
REQ-034 SHALL be verified for RAM = 0x00..0x0F and `dumping`=1, with an acknowledge pulse 2 cycles after each `data_valid`: `data_out` sequence 00,01,...,0F, then `done`=1; `bus_out` in each ADDR equals the index.
REQ-035 SHALL be verified for the control-word trace of byte 0: ADDR `out`=0x07E3 with `bus_drive`=1, READ `out`=0x0DE3 with `bus_drive`=0, PRESENT `out`=0x0FE3.
REQ-036 SHALL be verified with `next_byte` held high for 10 cycles in PRESENT: exactly one address advance, and the next byte waits for a fresh rising edge.
REQ-037 SHALL be verified with `dumping` dropped at byte 5 of the dump: IDLE next cycle, `data_valid`=0; on re-assert, the first byte is from address 0.
REQ-038 SHALL be verified with `rst`=1 during READ of byte 3: all outputs at reset values the next cycle, `out`=0x0FE3.
REQ-039 SHALL be verified, with `RAM_DUMPER_CHECKSUM_EN` defined and RAM all 0x11, as a 17th byte 0x10 (272 mod 256) followed by `done`=1.
